result_writer: RTL and testbench
================================

RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, meaning: number of 4-result groups buffered between capture and write-out.
REQ-002 Parameter ADDR_W, default 8, meaning: result RAM address width; upper 4 bits are matrix index, lower 4 bits are result index.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 web_in  input  1  one-cycle strobe from the MAC stage: mu1..mu4 hold a valid result group.
REQ-006 alu_done_in  input  1  one-cycle strobe: last group of the current matrix has been issued.
REQ-007 mu1, mu2, mu3, mu4  input  18 each  unsigned accumulated results, sampled only when web_in is high.
REQ-008 ram_csn  output  1  result RAM chip select, active-low.
REQ-009 ram_wen  output  1  result RAM write enable, active-low.
REQ-010 ram_addr  output  ADDR_W  result RAM word address.
REQ-011 ram_wdata  output  32  write data, {14'b0, result[17:0]}.
REQ-012 busy  output  1  high while FIFO non-empty, a write is in progress, or a done is pending.
REQ-013 done  output  1  one-cycle pulse: all results of one matrix are written.
REQ-014 ovf  output  1  sticky: a group was dropped because the FIFO was full.

Function
REQ-015 On every rising edge with web_in high, {mu1,mu2,mu3,mu4} SHALL be pushed into a FIFO_DEPTH-entry FIFO unless the FIFO is full.
REQ-016 A push attempted while the FIFO is full SHALL be discarded, with no change to FIFO contents, and ovf SHALL be set to 1 until reset.
REQ-017 The FSM SHALL have states IDLE and WRITE; IDLE -> WRITE when FIFO non-empty; WRITE lasts exactly 4 cycles (beat 0..3).
REQ-018 Beat b SHALL drive ram_csn=0, ram_wen=0, ram_addr={mat_idx, res_idx}, ram_wdata=zero-extended mu(b+1) from the FIFO head.
REQ-019 Beat 0 SHALL appear on registered outputs at edge N+1 when web_in is sampled high at edge N into an empty FIFO in IDLE.
REQ-020 The FIFO head SHALL pop at the edge ending beat 3; if the FIFO is still non-empty, beat 0 of the next group SHALL follow with no idle cycle.
REQ-021 WRITE -> IDLE after beat 3 when the FIFO is empty after the pop; in IDLE, ram_csn=1, ram_wen=1, and ram_addr/ram_wdata hold their last values.
REQ-022 res_idx (4 bits) SHALL increment after every beat and wrap 15 -> 0.
REQ-023 A push and a pop on the same edge SHALL both take effect, leaving occupancy unchanged.
REQ-024 alu_done_in high SHALL set done_pending; alu_done_in and web_in high on the same edge SHALL capture the group first, and done SHALL follow that group's writes.
REQ-025 When done_pending=1, the FIFO is empty, and the FSM is in IDLE, done SHALL pulse high for 1 cycle, done_pending SHALL clear, mat_idx (4 bits) SHALL increment with wrap 15 -> 0, and res_idx SHALL reset to 0.
REQ-026 A second alu_done_in while done_pending=1 SHALL be ignored.
REQ-027 busy = FIFO non-empty OR state==WRITE OR done_pending.

Reset
REQ-028 While rst=0, all state SHALL clear: FIFO empty, state IDLE, mat_idx=0, res_idx=0, done_pending=0.
REQ-029 While rst=0, outputs SHALL be ram_csn=1, ram_wen=1, ram_addr=0, ram_wdata=0, busy=0, done=0, ovf=0.
REQ-030 Reset asserted mid-WRITE SHALL deassert ram_csn/ram_wen immediately (asynchronously) and discard all buffered groups.
REQ-031 After rst rises, the first web_in SHALL be written starting at address 0x00.

Verification
REQ-032 Single group: web_in at edge N with mu1..4=1,2,3,0x3FFFF -> writes at edges N+1..N+4, addr 0x00..0x03, wdata 1,2,3,0x0003FFFF.
REQ-033 Full matrix: 4 groups spaced 8 cycles, alu_done_in with the last group -> 16 writes to 0x00..0x0F, one done pulse after the last write, next matrix starts at 0x10.
REQ-034 Back-to-back: web_in on 3 consecutive edges -> groups 1 and 2 written as 8 contiguous beats, group 3 dropped, ovf=1 and remains 1.
REQ-035 Wrap: 16 matrices completed -> 17th matrix writes start at 0x00; 16 done pulses observed.
REQ-036 Reset mid-write: rst low during beat 2 -> ram_csn=1 immediately, busy=0; next group after release writes to 0x00.
REQ-037 Late done: alu_done_in 5 cycles after the last group's writes finish -> done pulses on the edge after it is sampled, and busy is high for exactly that span.

Source files
------------

// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
//
// Buffers 4-result groups from the MAC stage and writes them one word per cycle
// into the result RAM. Each matrix occupies one 16-word page: the address is
// {mat_idx, res_idx}. Once the last group of a matrix has been written, a
// single-cycle done pulse is raised and the next page is selected.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   web_in          strobe: mu1..mu4 hold a result group to capture
//   alu_done_in     strobe: the last group of the current matrix has been issued
//   mu1..mu4        18-bit unsigned results
//   ram_csn/ram_wen result RAM chip select / write enable, active-low
//   ram_addr        result RAM word address {mat_idx, res_idx}
//   ram_wdata       zero-extended result word
//   busy            FIFO non-empty, write in progress, or done pending
//   done            one-cycle pulse when a matrix is completely written
//   ovf             sticky: a group was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module result_writer #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              web_in,
    input  logic              alu_done_in,
    input  logic [17:0]       mu1,
    input  logic [17:0]       mu2,
    input  logic [17:0]       mu3,
    input  logic [17:0]       mu4,
    output logic              ram_csn,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Element [0] is mu1, so beat b reads element [b].
    typedef logic [3:0][17:0] group_t;
    typedef enum logic {IDLE, WRITE} state_t;

    group_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic [1:0]       beat;
    logic [3:0]       mat_idx, res_idx;
    logic             done_pending;

    group_t grp_in, head, next_head;
    logic   full, empty, push, pop, more;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign grp_in    = {mu4, mu3, mu2, mu1};
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push      = web_in && !full;
    assign pop       = (state == WRITE) && (beat == 2'd3);
    assign rd_next   = ptr_inc(rd_ptr);
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_next];
    // Chaining into the next group only considers groups already stored; a
    // group arriving on the pop edge starts one cycle later via IDLE, the same
    // latency as a push into an empty FIFO.
    assign more      = (count > ONE_CNT);

    assign busy = !empty || (state == WRITE) || done_pending;

    // Group storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= grp_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            state        <= IDLE;
            beat         <= 2'd0;
            mat_idx      <= 4'd0;
            res_idx      <= 4'd0;
            done_pending <= 1'b0;
            ram_csn      <= 1'b1;
            ram_wen      <= 1'b1;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            done         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            // FIFO bookkeeping: a simultaneous push and pop leaves count as is.
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (web_in && full) ovf <= 1'b1;

            done <= 1'b0;
            // A repeated strobe while pending is absorbed: it sets a bit that
            // is already set, and the clear below wins on the firing edge.
            if (alu_done_in) done_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= WRITE;
                        beat      <= 2'd0;
                        ram_csn   <= 1'b0;
                        ram_wen   <= 1'b0;
                        ram_addr  <= ADDR_W'({mat_idx, res_idx});
                        ram_wdata <= {14'b0, head[0]};
                        res_idx   <= res_idx + 4'd1;
                    end else if (done_pending) begin
                        // Checked only in IDLE with an empty FIFO, so a group
                        // captured with the done strobe is written first.
                        done         <= 1'b1;
                        done_pending <= 1'b0;
                        mat_idx      <= mat_idx + 4'd1;
                        res_idx      <= 4'd0;
                    end
                end
                WRITE: begin
                    if (beat != 2'd3) begin
                        beat      <= beat + 2'd1;
                        ram_addr  <= ADDR_W'({mat_idx, res_idx});
                        ram_wdata <= {14'b0, head[beat + 2'd1]};
                        res_idx   <= res_idx + 4'd1;
                    end else if (more) begin
                        beat      <= 2'd0;
                        ram_addr  <= ADDR_W'({mat_idx, res_idx});
                        ram_wdata <= {14'b0, next_head[0]};
                        res_idx   <= res_idx + 4'd1;
                    end else begin
                        // Address and data hold their last values in IDLE.
                        state   <= IDLE;
                        beat    <= 2'd0;
                        ram_csn <= 1'b1;
                        ram_wen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// -----------------------------------------------------------------------------
// tb_result_writer
//
// Randomized scoreboard bench for result_writer. The reference model works in
// terms of whole groups: each accepted group occupies the FIFO from its push
// edge until its pop edge, starts writing at max(push+1, previous pop) and pops
// four cycles later. Expected writes (address, data, cycle) and done pulses
// (cycle) are queued when stimulus is issued; a negedge monitor pops and
// compares them whenever the DUT presents a write or a done pulse.
// -----------------------------------------------------------------------------
module tb_result_writer;

    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0, rst = 1'b1, web_in = 1'b0, alu_done_in = 1'b0;
    logic [17:0] mu1 = '0, mu2 = '0, mu3 = '0, mu4 = '0;
    logic        ram_csn, ram_wen, busy, done, ovf;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    int  n_tests = 0, n_fail = 0, cyc = 0;
    wr_t exp_wr[$];
    int  exp_done[$];
    int  pops[$];
    int  mat = 0, res = 0, last_pop = 0, ovf_edge = 0, last_done_edge = 0;
    int  dones_seen = 0;
    wr_t cur;
    int  dcyc;

    result_writer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .web_in(web_in), .alu_done_in(alu_done_in),
        .mu1(mu1), .mu2(mu2), .mu3(mu3), .mu4(mu4),
        .ram_csn(ram_csn), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("ovf", ovf, (ovf_edge != 0 && cyc >= ovf_edge) ? 1 : 0);
            if (exp_wr.size() != 0 && exp_wr[0].at < cyc) begin
                cur = exp_wr.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missed_write: addr 0x%0h due at cycle %0d not seen", cur.addr, cur.at);
            end
            if (exp_done.size() != 0 && exp_done[0] < cyc) begin
                dcyc = exp_done.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missed_done: pulse due at cycle %0d not seen", dcyc);
            end
            if (!ram_csn) begin
                chk("wen_low", ram_wen, 0);
                chk("busy_in_write", busy, 1);
                if (exp_wr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, none expected",
                             ram_addr, ram_wdata, cyc);
                end else begin
                    cur = exp_wr.pop_front();
                    chk("wr_addr", ram_addr, cur.addr);
                    chk("wr_data", ram_wdata, cur.data);
                    chk("wr_cycle", cyc, cur.at);
                end
            end
            if (done) begin
                dones_seen++;
                if (exp_done.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
                end else begin
                    chk("done_cycle", cyc, exp_done.pop_front());
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_done(input int d);
        int de;
        if (last_done_edge >= d) return;  // already pending: strobe ignored
        de = (d + 1 > last_pop + 1) ? d + 1 : last_pop + 1;
        exp_done.push_back(de);
        last_done_edge = de;
        mat = (mat + 1) % 16;
        res = 0;
    endtask

    task automatic issue_group(input logic [17:0] a, b, c, d, input bit dn);
        int e, occ, s;
        logic [17:0] v[4];
        e = cyc + 1;  // edge that samples these inputs
        web_in = 1'b1; alu_done_in = dn;
        mu1 = a; mu2 = b; mu3 = c; mu4 = d;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        occ = 0;
        foreach (pops[i]) if (pops[i] >= e) occ++;
        if (occ >= FIFO_DEPTH) begin
            if (ovf_edge == 0) ovf_edge = e;
        end else begin
            s = (e + 1 > last_pop) ? e + 1 : last_pop;
            for (int k = 0; k < 4; k++) begin
                exp_wr.push_back('{mat * 16 + res, int'(v[k]), s + k});
                res = (res + 1) % 16;
            end
            last_pop = s + 4;
            pops.push_back(s + 4);
        end
        if (dn) model_done(e);
        tick();
        web_in = 1'b0; alu_done_in = 1'b0;
    endtask

    task automatic issue_done();
        alu_done_in = 1'b1;
        model_done(cyc + 1);
        tick();
        alu_done_in = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle: %0d writes and %0d done pulses outstanding",
                     exp_wr.size(), exp_done.size());
            exp_wr.delete(); exp_done.delete();
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0; web_in = 1'b0; alu_done_in = 1'b0;
        #1;
        exp_wr.delete(); exp_done.delete(); pops.delete();
        mat = 0; res = 0; last_pop = 0; ovf_edge = 0; last_done_edge = 0;
        chk("rst_csn", ram_csn, 1);
        chk("rst_wen", ram_wen, 1);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        do_reset();

        // Single group then the rest of a 4-group matrix, 8 cycles apart.
        issue_group(18'd1, 18'd2, 18'd3, 18'h3FFFF, 1'b0);
        for (int g = 1; g < 4; g++) begin
            repeat (7) tick();
            issue_group(18'(g * 16 + 1), 18'(g * 16 + 2), 18'(g * 16 + 3), 18'(g * 16 + 4), g == 3);
        end
        wait_idle();

        // Late done: strobe 5 cycles after the writes finish.
        issue_group(18'h00AAA, 18'h15555, 18'h00000, 18'h3FFFF, 1'b0);
        wait_idle();
        repeat (4) tick();
        chk("late_busy_before", busy, 0);
        issue_done();
        chk("late_busy_pending", busy, 1);
        chk("late_done_low", done, 0);
        tick();
        chk("late_done_pulse", done, 1);
        chk("late_busy_after", busy, 0);
        tick();
        chk("late_done_single", done, 0);

        // Repeated done strobe while pending yields one pulse.
        issue_done();
        issue_done();
        wait_idle();

        // Back-to-back groups: third is dropped, ovf sticks.
        issue_group(18'h11111, 18'h22222, 18'h33333, 18'h04444, 1'b0);
        issue_group(18'h05555, 18'h06666, 18'h07777, 18'h08888, 1'b0);
        issue_group(18'h09999, 18'h0AAAA, 18'h0BBBB, 18'h0CCCC, 1'b0);
        issue_done();
        wait_idle();
        repeat (3) tick();
        chk("ovf_sticky", ovf, 1);

        // Reset during beat 2 of a write.
        issue_group(18'h00123, 18'h00456, 18'h00789, 18'h00ABC, 1'b0);
        repeat (3) tick();
        chk("beat2_active", ram_csn, 0);
        chk("beat2_addr", ram_addr, 8'h42);
        do_reset();
        issue_group(18'h00321, 18'h00654, 18'h00987, 18'h00CBA, 1'b1);
        wait_idle();

        // Random matrices: crosses the 16-matrix wrap, with occasional drops.
        dones_seen = 0;
        for (int m = 0; m < 20; m++) begin
            int ng;
            bit late;
            ng   = $urandom_range(1, 5);
            late = ($urandom_range(0, 1) == 1);
            for (int g = 0; g < ng; g++) begin
                repeat ($urandom_range(0, 9)) tick();
                issue_group(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)),
                            18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)),
                            !late && (g == ng - 1));
            end
            if (late) begin
                repeat ($urandom_range(0, 12)) tick();
                issue_done();
            end
            wait_idle();
        end
        chk("done_count", dones_seen, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
